// File: rtl/mod_inverse_443_pkg.sv
// Shared constants and state encoding for the GF(443) inverse unit.
// Default field parameters, derived datapath widths, FSM states.
`timescale 1ns/1ps
package mod_inverse_443_pkg;

    localparam int Q_DEF  = 443;
    localparam int K_DEF  = 9;
    localparam int MU_DEF = 591;
    localparam int W2     = 2 * K_DEF;
    localparam int W2P    = 2 * K_DEF + 1;

    localparam logic [K_DEF-1:0] EXP_DEF = 9'b110111001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SQR,
        ST_MUL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mod_inverse_443_barrett_reduce_wide.sv
// Combinational Barrett reducer: r = x mod Q for a 2K-bit x.
// Ports: x (2K-bit product in), r (K-bit residue out, 0..Q-1).
`timescale 1ns/1ps
module barrett_reduce_wide
    import mod_inverse_443_pkg::*;
#(
    parameter int Q  = Q_DEF,
    parameter int K  = K_DEF,
    parameter int MU = MU_DEF
) (
    input  logic [2*K-1:0] x,
    output logic [K-1:0]   r
);

    localparam logic [2*K:0] Q_W  = (2*K+1)'(Q);
    localparam logic [2*K:0] MU_W = (2*K+1)'(MU);

    logic [2*K:0] q1;
    logic [2*K:0] q2;
    logic [2*K:0] tq;
    logic [2*K:0] r0;
    logic [2*K:0] r1;
    logic [2*K:0] r2;

    always_comb begin
        q1 = (2*K+1)'(x >> K);
        q2 = q1 * MU_W;
        // Quotient estimate undershoots by at most 2, so r0 < 3Q.
        tq = (q2 >> K) * Q_W;
        r0 = {1'b0, x} - tq;
        r1 = (r0 >= Q_W) ? r0 - Q_W : r0;
        r2 = (r1 >= Q_W) ? r1 - Q_W : r1;
        r  = K'(r2);
    end

endmodule

// File: rtl/mod_inverse_443.sv
// Fermat inverse over GF(Q): dout_r = din_a^(Q-2) mod Q, one mul per cycle.
// Ports: clk, rst (sync, active-high); din_valid/din_ready/din_a operand
// handshake; dout_valid/dout_ready/dout_r/dout_err result handshake.
`timescale 1ns/1ps
module mod_inverse_443
    import mod_inverse_443_pkg::*;
#(
    parameter int           Q   = Q_DEF,
    parameter int           K   = K_DEF,
    parameter int           MU  = MU_DEF,
    parameter logic [K-1:0] EXP = EXP_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic [K-1:0] din_a,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [K-1:0] dout_r,
    output logic         dout_err
);

    localparam int           IW  = $clog2(K);
    localparam logic [K-1:0] Q_K = K'(Q);
    localparam logic [IW-1:0] I_START = IW'(K - 2);

    state_t        state;
    state_t        state_n;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_n;
    logic [K-1:0]  acc;
    logic [K-1:0]  base;
    logic          zero;

    logic [K-1:0]   a_red;
    logic [K-1:0]   m2;
    logic [2*K-1:0] prod;
    logic [K-1:0]   red;
    logic           accept;

    assign din_ready = (state == ST_IDLE) & ~rst;
    assign accept    = din_valid & din_ready;

    // Inputs are below 2^K < 2Q, so one subtraction fully reduces.
    assign a_red = (din_a >= Q_K) ? din_a - Q_K : din_a;

    assign m2   = (state == ST_MUL) ? base : acc;
    assign prod = (2*K)'(acc) * (2*K)'(m2);

    barrett_reduce_wide #(
        .Q  (Q),
        .K  (K),
        .MU (MU)
    ) u_reduce (
        .x (prod),
        .r (red)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_SQR;
                    idx_n   = I_START;
                end
            end
            ST_SQR: begin
                if (EXP[idx]) begin
                    state_n = ST_MUL;
                end else if (idx == '0) begin
                    state_n = ST_DONE;
                end else begin
                    idx_n = idx - 1'b1;
                end
            end
            ST_MUL: begin
                if (idx == '0) begin
                    state_n = ST_DONE;
                end else begin
                    idx_n   = idx - 1'b1;
                    state_n = ST_SQR;
                end
            end
            ST_DONE: begin
                if (dout_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            acc        <= '0;
            base       <= '0;
            zero       <= 1'b0;
            dout_valid <= 1'b0;
            dout_r     <= '0;
            dout_err   <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (accept) begin
                base <= a_red;
                acc  <= a_red;
                zero <= (a_red == '0);
            end
            if (state == ST_SQR || state == ST_MUL) begin
                acc <= red;
            end
            // Result register loads on the last op so DONE is glitch-free.
            if (state != ST_DONE && state_n == ST_DONE) begin
                dout_valid <= 1'b1;
                dout_r     <= zero ? '0 : red;
                dout_err   <= zero;
            end else if (state == ST_DONE && dout_ready) begin
                dout_valid <= 1'b0;
                dout_r     <= '0;
                dout_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mod_inverse_443.sv
// Self-checking bench for mod_inverse_443: vectors, corner sequences,
// exhaustive sweep and random operands against an arithmetic model.
`timescale 1ns/1ps
module tb_mod_inverse_443;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_valid;
    logic       din_ready;
    logic [8:0] din_a;
    logic       dout_valid;
    logic       dout_ready;
    logic [8:0] dout_r;
    logic       dout_err;

    int checks   = 0;
    int failures = 0;

    mod_inverse_443 dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_a      (din_a),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_r     (dout_r),
        .dout_err   (dout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int r;
        int err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // a^(Q-2) mod Q by repeated multiplication; 0 has no inverse.
    function automatic int ref_inv(input int a);
        int b;
        int r;
        b = a % 443;
        if (b == 0) return 0;
        r = 1;
        for (int i = 0; i < 441; i++) r = (r * b) % 443;
        return r;
    endfunction

    task automatic do_op(input int a, input int hold, input string tag,
                         output int r, output int e, output int lat);
        int w;
        @(negedge clk);
        din_a     = a[8:0];
        din_valid = 1'b1;
        w = 0;
        while (!din_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({tag, " din_ready_at_accept"}, din_ready, 1);
        @(negedge clk);
        din_valid = 1'b0;
        din_a     = 9'($urandom);
        lat = 1;
        while (!dout_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = dout_r;
        e = dout_err;
        chk({tag, " latency"}, lat, 14);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, " held_valid"}, dout_valid, 1);
            chk({tag, " held_r"}, dout_r, r);
            chk({tag, " held_din_ready"}, din_ready, 0);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        chk({tag, " valid_dropped"}, dout_valid, 0);
        chk({tag, " din_ready_back"}, din_ready, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        int e;
        int lat;
        int a;
        int hold;
        bit seen;

        vecs[0] = '{a: 2,   r: 222, err: 0};
        vecs[1] = '{a: 3,   r: 148, err: 0};
        vecs[2] = '{a: 442, r: 442, err: 0};
        vecs[3] = '{a: 1,   r: 1,   err: 0};
        vecs[4] = '{a: 444, r: 1,   err: 0};
        vecs[5] = '{a: 0,   r: 0,   err: 1};
        vecs[6] = '{a: 443, r: 0,   err: 1};
        vecs[7] = '{a: 5,   r: 266, err: 0};

        rst        = 1'b1;
        din_valid  = 1'b0;
        din_a      = '0;
        dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset dout_valid", dout_valid, 0);
        chk("reset dout_r", dout_r, 0);
        chk("reset dout_err", dout_err, 0);
        chk("reset din_ready", din_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset din_ready", din_ready, 1);

        foreach (vecs[i]) begin
            do_op(vecs[i].a, 0, $sformatf("vec%0d", i), r, e, lat);
            chk($sformatf("vec%0d r", i), r, vecs[i].r);
            chk($sformatf("vec%0d err", i), e, vecs[i].err);
        end

        do_op(3, 10, "backpressure", r, e, lat);
        chk("backpressure r", r, 148);

        @(negedge clk);
        din_a     = 9'd5;
        din_valid = 1'b1;
        chk("abort din_ready", din_ready, 1);
        @(negedge clk);
        din_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dout_valid) seen = 1'b1;
        end
        chk("abort no_result", seen, 0);
        chk("abort din_ready_idle", din_ready, 1);
        do_op(5, 0, "after_abort", r, e, lat);
        chk("after_abort r", r, 266);

        for (int v = 1; v < 443; v++) begin
            do_op(v, 0, $sformatf("sweep%0d", v), r, e, lat);
            chk($sformatf("sweep%0d product", v), (v * r) % 443, 1);
        end

        for (int n = 0; n < 60; n++) begin
            a    = $urandom_range(0, 511);
            hold = $urandom_range(0, 3);
            do_op(a, hold, $sformatf("rand%0d", n), r, e, lat);
            chk($sformatf("rand%0d r a=%0d", n, a), r, ref_inv(a));
            chk($sformatf("rand%0d err a=%0d", n, a), e,
                (a % 443 == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
